// File: rtl/scrambler_frm.sv
// Additive Fibonacci LFSR scrambler/descrambler; DATA_W key bits per beat, reseeded on every frame start.
// Latency: one cycle from an accepted beat to out_valid; frame_done pulses the cycle after the last accept.
// Backpressure: in_ready needs RUN and a free or draining output slot; LFSR and beat count hold without an accept.
module scrambler_frm #(
    parameter int                LFSR_W    = 10,
    parameter logic [LFSR_W-1:0] TAPS      = 10'b10_0000_0100,
    parameter logic [LFSR_W-1:0] SEED      = '1,
    parameter int                DATA_W    = 1,
    parameter int                FRAME_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              bypass,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              frame_done
);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam int               CNT_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(FRAME_LEN - 1);

    state_t              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]   lfsr_adv;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                out_vld_q, out_vld_d;
    logic [DATA_W-1:0]   out_dat_q, out_dat_d;
    logic [DATA_W-1:0]   key;
    logic                accept;

    assign in_ready   = busy_q & (~out_vld_q | out_ready);
    assign accept     = in_valid & in_ready;
    assign out_valid  = out_vld_q;
    assign out_data   = out_dat_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    // Unrolled keystream: key[i] is the feedback bit after i single steps from the beat's start state.
    always_comb begin
        lfsr_adv = lfsr_q;
        key      = '0;
        for (int i = 0; i < DATA_W; i++) begin
            key[i]   = ^(lfsr_adv & TAPS);
            lfsr_adv = {lfsr_adv[LFSR_W-2:0], key[i]};
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        out_vld_d = out_vld_q;
        out_dat_d = out_dat_q;

        if (accept) begin
            out_vld_d = 1'b1;
            out_dat_d = bypass ? in_data : (in_data ^ key);
        end else if (out_ready) begin
            out_vld_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                // start is deliberately not looked at here, even alongside the last beat
                if (accept) begin
                    lfsr_d = lfsr_adv;
                    if (cnt_q == LAST_BEAT) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= SEED;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            out_vld_q <= out_vld_d;
            out_dat_q <= out_dat_d;
        end
    end

endmodule
